// File: rtl/mchan_twd_pkg.sv
// Shared definitions for the MCHAN 2D transfer splitter and the 2D parameter queue.
// Queue entries are laid out as {stride, count}, with count in the low bits.
package mchan_twd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } twd_state_e;

  localparam int unsigned TWD_COUNT_W_DEF  = 16;
  localparam int unsigned TWD_STRIDE_W_DEF = 16;
  localparam int unsigned TWD_COUNT_LSB    = 0;
  localparam int unsigned TWD_STRIDE_LSB   = TWD_COUNT_LSB + TWD_COUNT_W_DEF;

endpackage

// File: rtl/mchan_twd_splitter_ipa.sv
// Splits 2D MCHAN commands into 1D row transfers; 1D commands pass through as a
// single row. Row fields are registers, so nothing on in_* reaches out_* combinationally.
module mchan_twd_splitter_ipa
  import mchan_twd_pkg::*;
#(
  parameter int ADDR_WIDTH          = 32,
  parameter int TRANS_SIZE          = 16,
  parameter int TWD_COUNT_WIDTH     = TWD_COUNT_W_DEF,
  parameter int TWD_STRIDE_WIDTH    = TWD_STRIDE_W_DEF,
  parameter int TWD_QUEUE_WIDTH     = TWD_COUNT_WIDTH + TWD_STRIDE_WIDTH,
  parameter int TWD_QUEUE_DEPTH     = 4,
  parameter int TWD_QUEUE_ADD_WIDTH = $clog2(TWD_QUEUE_DEPTH),
  parameter int TID_WIDTH           = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           in_req_i,
  output logic                           in_gnt_o,
  input  logic                           in_opc_i,
  input  logic [TRANS_SIZE-1:0]          in_len_i,
  input  logic [ADDR_WIDTH-1:0]          in_tcdm_add_i,
  input  logic [ADDR_WIDTH-1:0]          in_ext_add_i,
  input  logic                           in_twd_i,
  input  logic [TWD_QUEUE_ADD_WIDTH-1:0] in_twd_add_i,
  input  logic [TID_WIDTH-1:0]           in_tid_i,
  output logic                           twd_rd_req_o,
  output logic [TWD_QUEUE_ADD_WIDTH-1:0] twd_rd_add_o,
  input  logic [TWD_QUEUE_WIDTH-1:0]     twd_rd_dat_i,
  output logic                           out_req_o,
  input  logic                           out_gnt_i,
  output logic                           out_opc_o,
  output logic [TRANS_SIZE-1:0]          out_len_o,
  output logic [ADDR_WIDTH-1:0]          out_tcdm_add_o,
  output logic [ADDR_WIDTH-1:0]          out_ext_add_o,
  output logic [TID_WIDTH-1:0]           out_tid_o,
  output logic                           out_last_o,
  output logic                           busy_o
);

  twd_state_e                state_r;
  logic                      opc_r;
  logic [TID_WIDTH-1:0]      tid_r;
  logic [TRANS_SIZE-1:0]     rem_r;
  logic [TRANS_SIZE-1:0]     count_r;
  logic [ADDR_WIDTH-1:0]     stride_r;
  logic [ADDR_WIDTH-1:0]     tcdm_r;
  logic [ADDR_WIDTH-1:0]     ext_r;
  logic [TRANS_SIZE-1:0]     len_r;
  logic                      last_r;

  logic                      accept_s;
  logic [TWD_COUNT_WIDTH-1:0]  q_count_s;
  logic [TWD_STRIDE_WIDTH-1:0] q_stride_s;
  logic [TRANS_SIZE-1:0]     count_sel_s;
  logic [ADDR_WIDTH-1:0]     stride_sel_s;
  logic [TRANS_SIZE-1:0]     rem_next_s;

  function automatic logic [TRANS_SIZE-1:0] min_len(input logic [TRANS_SIZE-1:0] a,
                                                    input logic [TRANS_SIZE-1:0] b);
    if (a < b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  assign accept_s   = (state_r == IDLE) && in_req_i;
  assign q_count_s  = twd_rd_dat_i[TWD_COUNT_LSB +: TWD_COUNT_WIDTH];
  assign q_stride_s = twd_rd_dat_i[TWD_COUNT_LSB + TWD_COUNT_WIDTH +: TWD_STRIDE_WIDTH];
  assign rem_next_s = rem_r - count_r;

  // Row geometry for a new command; a zero queue count degenerates to one full-length row.
  always_comb begin
    count_sel_s  = in_len_i;
    stride_sel_s = '0;
    if (in_twd_i) begin
      stride_sel_s = ADDR_WIDTH'(q_stride_s);
      if (q_count_s != '0) begin
        count_sel_s = TRANS_SIZE'(q_count_s);
      end else begin
        count_sel_s = in_len_i;
      end
    end else begin
      count_sel_s  = in_len_i;
      stride_sel_s = '0;
    end
  end

  // The queue slot is read and freed only in the accept cycle.
  assign twd_rd_req_o = accept_s && in_twd_i;
  assign twd_rd_add_o = twd_rd_req_o ? in_twd_add_i : '0;

  assign in_gnt_o       = (state_r == IDLE);
  assign busy_o         = (state_r == ISSUE);
  assign out_req_o      = (state_r == ISSUE);
  assign out_opc_o      = opc_r;
  assign out_tid_o      = tid_r;
  assign out_len_o      = len_r;
  assign out_last_o     = last_r;
  assign out_tcdm_add_o = tcdm_r;
  assign out_ext_add_o  = ext_r;

  // Command FSM and row datapath; the next row's length/last are precomputed on each grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= IDLE;
      opc_r    <= 1'b0;
      tid_r    <= '0;
      rem_r    <= '0;
      count_r  <= '0;
      stride_r <= '0;
      tcdm_r   <= '0;
      ext_r    <= '0;
      len_r    <= '0;
      last_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_req_i) begin
            opc_r    <= in_opc_i;
            tid_r    <= in_tid_i;
            rem_r    <= in_len_i;
            count_r  <= count_sel_s;
            stride_r <= stride_sel_s;
            tcdm_r   <= in_tcdm_add_i;
            ext_r    <= in_ext_add_i;
            len_r    <= min_len(count_sel_s, in_len_i);
            last_r   <= (in_len_i <= count_sel_s);
            state_r  <= ISSUE;
          end
        end
        ISSUE: begin
          if (out_gnt_i) begin
            if (last_r) begin
              state_r <= IDLE;
            end else begin
              rem_r   <= rem_next_s;
              tcdm_r  <= tcdm_r + ADDR_WIDTH'(count_r);
              ext_r   <= ext_r + stride_r;
              len_r   <= min_len(count_r, rem_next_s);
              last_r  <= (rem_next_s <= count_r);
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mchan_twd_splitter_ipa.sv
// Self-checking bench for mchan_twd_splitter_ipa: a row scoreboard filled from a
// reference model of the split, drained by a monitor on the output handshake.
module tb_mchan_twd_splitter_ipa;

  typedef struct packed {
    logic        opc;
    logic [3:0]  tid;
    logic [15:0] len;
    logic [31:0] tcdm;
    logic [31:0] ext;
    logic        last;
  } row_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_req_i = 1'b0;
  logic        in_gnt_o;
  logic        in_opc_i = 1'b0;
  logic [15:0] in_len_i = 16'd0;
  logic [31:0] in_tcdm_add_i = 32'd0;
  logic [31:0] in_ext_add_i = 32'd0;
  logic        in_twd_i = 1'b0;
  logic [1:0]  in_twd_add_i = 2'd0;
  logic [3:0]  in_tid_i = 4'd0;
  logic        twd_rd_req_o;
  logic [1:0]  twd_rd_add_o;
  logic [31:0] twd_rd_dat_i;
  logic        out_req_o;
  logic        out_gnt_i = 1'b0;
  logic        out_opc_o;
  logic [15:0] out_len_o;
  logic [31:0] out_tcdm_add_o;
  logic [31:0] out_ext_add_o;
  logic [3:0]  out_tid_o;
  logic        out_last_o;
  logic        busy_o;

  logic [31:0] qmem [4];
  row_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  int          rd_pulses = 0;

  assign twd_rd_dat_i = qmem[twd_rd_add_o];

  always #5 clk_i = ~clk_i;

  mchan_twd_splitter_ipa dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_opc_i(in_opc_i), .in_len_i(in_len_i),
    .in_tcdm_add_i(in_tcdm_add_i), .in_ext_add_i(in_ext_add_i), .in_twd_i(in_twd_i),
    .in_twd_add_i(in_twd_add_i), .in_tid_i(in_tid_i),
    .twd_rd_req_o(twd_rd_req_o), .twd_rd_add_o(twd_rd_add_o), .twd_rd_dat_i(twd_rd_dat_i),
    .out_req_o(out_req_o), .out_gnt_i(out_gnt_i), .out_opc_o(out_opc_o), .out_len_o(out_len_o),
    .out_tcdm_add_o(out_tcdm_add_o), .out_ext_add_o(out_ext_add_o), .out_tid_o(out_tid_o),
    .out_last_o(out_last_o), .busy_o(busy_o)
  );

  // Output monitor: every granted row is checked against the head of the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni && twd_rd_req_o) rd_pulses++;
    if (rst_ni && out_req_o && out_gnt_i) begin
      row_t got;
      row_t exp;
      got = '{opc: out_opc_o, tid: out_tid_o, len: out_len_o, tcdm: out_tcdm_add_o,
              ext: out_ext_add_o, last: out_last_o};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL row_unexpected: got len=%0d tcdm=%h ext=%h last=%b, expected no row",
                 got.len, got.tcdm, got.ext, got.last);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL row: got opc=%b tid=%h len=%0d tcdm=%h ext=%h last=%b, expected opc=%b tid=%h len=%0d tcdm=%h ext=%h last=%b",
                   got.opc, got.tid, got.len, got.tcdm, got.ext, got.last,
                   exp.opc, exp.tid, exp.len, exp.tcdm, exp.ext, exp.last);
        end
      end
    end
  end

  // Reference model: expected rows for one command, pushed at stimulus time.
  task automatic push_expected(input logic opc, input logic [15:0] len, input logic [31:0] tcdm,
                               input logic [31:0] ext, input logic twd, input logic [1:0] slot,
                               input logic [3:0] tid);
    int unsigned rem;
    int unsigned cnt;
    logic [31:0] stride;
    logic [31:0] t;
    logic [31:0] e;
    row_t r;
    rem = len; t = tcdm; e = ext;
    if (twd) begin
      cnt    = qmem[slot][15:0];
      stride = {16'd0, qmem[slot][31:16]};
      if (cnt == 0) cnt = len;
    end else begin
      cnt    = len;
      stride = 32'd0;
    end
    forever begin
      r.opc = opc; r.tid = tid; r.tcdm = t; r.ext = e;
      r.len  = 16'((rem < cnt) ? rem : cnt);
      r.last = (rem <= cnt);
      sb.push_back(r);
      if (r.last) break;
      rem = rem - cnt;
      t   = t + cnt;
      e   = e + stride;
    end
  endtask

  function automatic logic gnt_pattern(input int k, input logic bp);
    if (!bp) return 1'b1;
    return (k % 3 == 0);
  endfunction

  // Issue one command and run it to completion, checking handshake timing and stability.
  task automatic run_cmd(input string name, input logic opc, input logic [15:0] len,
                         input logic [31:0] tcdm, input logic [31:0] ext, input logic twd,
                         input logic [1:0] slot, input logic [3:0] tid, input logic bp);
    int   k;
    int   pulses0;
    logic stalled;
    row_t saved;
    row_t cur;
    push_expected(opc, len, tcdm, ext, twd, slot, tid);
    pulses0 = rd_pulses;
    @(posedge clk_i); #1;
    in_req_i = 1'b1; in_opc_i = opc; in_len_i = len; in_tcdm_add_i = tcdm;
    in_ext_add_i = ext; in_twd_i = twd; in_twd_add_i = slot; in_tid_i = tid;
    @(negedge clk_i);
    checks++;
    if (in_gnt_o !== 1'b1) begin
      errors++; $display("FAIL %s accept_gnt: got %b expected 1", name, in_gnt_o);
    end
    checks++;
    if (twd_rd_req_o !== twd || (twd && twd_rd_add_o !== slot)) begin
      errors++;
      $display("FAIL %s rd_req: got req=%b add=%0d expected req=%b add=%0d",
               name, twd_rd_req_o, twd_rd_add_o, twd, slot);
    end
    checks++;
    if (out_req_o !== 1'b0) begin
      errors++; $display("FAIL %s comb_path: out_req=%b in accept cycle expected 0", name, out_req_o);
    end
    @(posedge clk_i); #1;
    in_req_i = 1'b0; in_twd_i = 1'b0;
    out_gnt_i = gnt_pattern(0, bp);
    @(negedge clk_i);
    checks++;
    if (out_req_o !== 1'b1) begin
      errors++; $display("FAIL %s first_row_latency: out_req=%b expected 1", name, out_req_o);
    end
    k = 0; stalled = 1'b0;
    while (busy_o === 1'b1 && k < 200) begin
      cur = '{opc: out_opc_o, tid: out_tid_o, len: out_len_o, tcdm: out_tcdm_add_o,
              ext: out_ext_add_o, last: out_last_o};
      checks++;
      if (in_gnt_o !== 1'b0) begin
        errors++; $display("FAIL %s in_gnt_busy: got %b expected 0", name, in_gnt_o);
      end
      if (stalled) begin
        checks++;
        if (cur !== saved) begin
          errors++;
          $display("FAIL %s stall_stable: got len=%0d tcdm=%h ext=%h expected len=%0d tcdm=%h ext=%h",
                   name, cur.len, cur.tcdm, cur.ext, saved.len, saved.tcdm, saved.ext);
        end
      end
      stalled = out_req_o && !out_gnt_i;
      saved   = cur;
      @(posedge clk_i); #1;
      k++;
      out_gnt_i = gnt_pattern(k, bp);
      @(negedge clk_i);
    end
    checks++;
    if (k >= 200) begin
      errors++; $display("FAIL %s timeout: busy after %0d cycles, expected idle", name, k);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL %s rows_missing: %0d rows left expected 0", name, sb.size());
      sb.delete();
    end
    checks++;
    if (rd_pulses - pulses0 != (twd ? 1 : 0)) begin
      errors++;
      $display("FAIL %s rd_pulse_count: got %0d expected %0d", name, rd_pulses - pulses0, twd ? 1 : 0);
    end
    out_gnt_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    checks++;
    if (in_gnt_o !== 1'b1 || out_req_o !== 1'b0 || twd_rd_req_o !== 1'b0 ||
        out_last_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt=%b req=%b rd=%b last=%b busy=%b expected 1 0 0 0 0",
               in_gnt_o, out_req_o, twd_rd_req_o, out_last_o, busy_o);
    end
    checks++;
    if (out_len_o !== 16'd0 || out_tcdm_add_o !== 32'd0 || out_ext_add_o !== 32'd0 ||
        out_tid_o !== 4'd0 || out_opc_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: len=%h tcdm=%h ext=%h tid=%h opc=%b expected all 0",
               out_len_o, out_tcdm_add_o, out_ext_add_o, out_tid_o, out_opc_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_1d();
    run_cmd("pass_1d", 1'b0, 16'd64, 32'h0000_1000, 32'h8000_0000, 1'b0, 2'd0, 4'h3, 1'b0);
  endtask

  task automatic test_2d_even();
    qmem[2] = {16'h0100, 16'd8};
    run_cmd("even_2d", 1'b1, 16'd32, 32'h0000_2000, 32'h4000_0000, 1'b1, 2'd2, 4'h5, 1'b0);
  endtask

  task automatic test_2d_remainder();
    qmem[1] = {16'h0040, 16'd8};
    run_cmd("rem_2d", 1'b0, 16'd20, 32'h0000_0300, 32'h1000_0000, 1'b1, 2'd1, 4'h9, 1'b0);
  endtask

  task automatic test_backpressure();
    qmem[2] = {16'h0100, 16'd8};
    run_cmd("backpressure", 1'b1, 16'd32, 32'h0000_2000, 32'h4000_0000, 1'b1, 2'd2, 4'hA, 1'b1);
  endtask

  task automatic test_edges();
    qmem[0] = {16'h0010, 16'd0};
    run_cmd("count_zero", 1'b0, 16'd16, 32'h0000_0040, 32'h0000_0080, 1'b1, 2'd0, 4'h1, 1'b0);
    run_cmd("len_zero", 1'b1, 16'd0, 32'h0000_0050, 32'h0000_0090, 1'b0, 2'd0, 4'h2, 1'b0);
    qmem[3] = {16'h0020, 16'd8};
    run_cmd("ext_wrap", 1'b0, 16'd16, 32'h0000_0000, 32'hFFFF_FFF0, 1'b1, 2'd3, 4'h4, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_cmd("b2b_a", 1'b1, 16'd12, 32'h0000_0A00, 32'h0000_0B00, 1'b0, 2'd0, 4'h6, 1'b0);
    qmem[1] = {16'h0200, 16'd5};
    run_cmd("b2b_b", 1'b0, 16'd11, 32'h0000_0C00, 32'h0000_0D00, 1'b1, 2'd1, 4'h7, 1'b0);
  endtask

  task automatic test_reset_mid();
    qmem[2] = {16'h0100, 16'd8};
    push_expected(1'b0, 16'd32, 32'h0000_5000, 32'h6000_0000, 1'b1, 2'd2, 4'hB);
    @(posedge clk_i); #1;
    in_req_i = 1'b1; in_opc_i = 1'b0; in_len_i = 16'd32; in_tcdm_add_i = 32'h0000_5000;
    in_ext_add_i = 32'h6000_0000; in_twd_i = 1'b1; in_twd_add_i = 2'd2; in_tid_i = 4'hB;
    @(posedge clk_i); #1;
    in_req_i = 1'b0; in_twd_i = 1'b0; out_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (out_req_o !== 1'b0 || in_gnt_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: req=%b gnt=%b busy=%b expected 0 1 0", out_req_o, in_gnt_o, busy_o);
    end
    checks++;
    if (sb.size() != 3) begin
      errors++; $display("FAIL reset_mid_rows: %0d rows pending expected 3", sb.size());
    end
    sb.delete();
    out_gnt_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_cmd("after_reset", 1'b1, 16'd24, 32'h0000_0700, 32'h0000_0800, 1'b0, 2'd0, 4'hC, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) qmem[i] = 32'd0;
    test_reset();
    test_1d();
    test_2d_even();
    test_2d_remainder();
    test_backpressure();
    test_edges();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
